ifetch_buffer: RTL and testbench

Instruction prefetch buffer between a variable-latency instruction memory port and the core's decode stage. It owns the fetch address and issues sequential word requests over a request/grant/valid handshake. In-order responses are queued with their PCs and handed to the core over a valid/ready interface. A redirect from the core's branch/jump logic flushes the queue, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/ifb_pkg.sv | 23 ++
 rtl/ifb_fifo.sv | 66 ++++++
 rtl/ifetch_buffer.sv | 117 +++++++++++
 tb/tb_ifetch_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
// ifb_pkg: shared types and constants for the instruction prefetch buffer.
// Build option IFB_BYPASS_EN is consumed by ifetch_buffer, not here.
package ifb_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00400000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo: DEPTH-entry queue of {pc, instr} with push, pop and clear.
// Clear wins over push/pop; the head is only meaningful when count_o != 0.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      clear_i,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               instr_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [31:0]               head_pc_o,
  output logic [31:0]               head_instr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign head         = mem_q[rd_q];
  assign head_pc_o    = head.pc;
  assign head_instr_o = head.instr;
  assign count_o      = cnt_q;

  // Pointer and occupancy next-state; pointers wrap on the power-of-2 depth.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wr_d = wr_q + AW'(1);
    if (pop_i)  rd_d = rd_q + AW'(1);
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  // Entry storage; contents past the tail are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= '{pc: pc_i, instr: instr_i};
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: sequential instruction prefetch with redirect and flush.
// Define IFB_BYPASS_EN to forward a response straight to decode on empty.
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = DEPTH[CW:0];

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [31:0]   head_pc, head_instr;
  logic [31:0]   tgt;
  logic          gnt_fire, drop, push, pop;
  logic          fifo_push, fifo_pop;

  assign tgt      = word_align(redirect_pc);
  assign occ      = {1'b0, count} + {1'b0, out_q};
  assign mem_req  = !rst && (state_q != BOOT)
                  && !redirect && (occ < LIMIT);
  assign mem_addr = fetch_pc_q;
  assign gnt_fire = mem_req && mem_gnt;
  assign drop     = mem_rvalid && (disc_q != '0);
  assign push     = mem_rvalid && !drop && !redirect;

`ifdef IFB_BYPASS_EN
  logic byp;
  assign byp         = (count == '0) && (disc_q == '0) && mem_rvalid;
  assign instr_valid = (count != '0) || byp;
  assign instr       = (count != '0) ? head_instr
                     : (byp ? mem_rdata : NOP_INSTR);
  assign instr_pc    = (count != '0) ? head_pc : resp_pc_q;
  assign fifo_push   = push && !(byp && instr_ready);
`else
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head_instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head_pc : resp_pc_q;
  assign fifo_push   = push;
`endif

  assign pop      = instr_valid && instr_ready;
  assign fifo_pop = pop && (count != '0);

  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fifo_push),
    .pop_i        (fifo_pop),
    .clear_i      (redirect),
    .pc_i         (resp_pc_q),
    .instr_i      (mem_rdata),
    .count_o      (count),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr)
  );

  // PCs, credit counters and FSM; a redirect turns in-flight words into discards.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(gnt_fire) - CW'(mem_rvalid);
    disc_d     = disc_q - CW'(drop);
    if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)     resp_pc_d  = resp_pc_q + 32'd4;
    if (redirect) begin
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      disc_d     = out_d;
    end
    unique case (state_q)
      BOOT:         state_d = FETCH;
      FETCH, DRAIN: state_d = (disc_d != '0) ? DRAIN : FETCH;
      default:      state_d = BOOT;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: table vectors, directed corners and random traffic
// against a stream-level model of the prefetch buffer.
module tb_ifetch_buffer;
  import ifb_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    bit          rdy;
    bit          gnt;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  mreq_t memq[$];
  vec_t  tbl[8];

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  int buffered = 0;
  int ndrop = 0;
  int ndeliv = 0;
  int ngnt = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rv_pct = 100;
  bit boot = 1'b0;
  logic [31:0] exp_fetch = RPC;
  logic [31:0] exp_pc = RPC;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, ncyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    memq.delete();
    buffered = 0;
    exp_fetch = RPC;
    exp_pc = RPC;
    boot = 1'b1;
  endtask

  // One clock: drive, check at negedge against the model, advance model.
  task automatic cyc(input bit rdy, input bit gnt, input bit redir,
                     input logic [31:0] rpc);
    bit    ex_req;
    mreq_t e;
    instr_ready = rdy;
    mem_gnt = gnt;
    redirect = redir;
    redirect_pc = rpc;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (memq.size() > 0 && memq[0].due <= ncyc
        && int'($urandom_range(99)) < rv_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata = word_of(memq[0].addr);
    end
    @(negedge clk);
    s_req = mem_req;
    s_addr = mem_addr;
    s_valid = instr_valid;
    s_pc = instr_pc;
    s_instr = instr;
    ex_req = !boot && !redir && (memq.size() + buffered < DEPTH);
    chk("mem_req", 32'(s_req), 32'(ex_req));
    if (boot) chk("boot_addr", s_addr, RPC);
    if (s_req && gnt) chk("mem_addr", s_addr, exp_fetch);
    chk("instr_valid", 32'(s_valid), 32'(buffered > 0));
    if (s_valid) begin
      chk("instr_pc", s_pc, exp_pc);
      chk("instr", s_instr, word_of(exp_pc));
    end else begin
      chk("instr_nop", s_instr, NOP_INSTR);
    end
    if (s_valid && rdy) begin
      buffered--;
      exp_pc += 32'd4;
      ndeliv++;
    end
    if (s_req && gnt) begin
      memq.push_back('{addr: exp_fetch,
                       due: ncyc + int'($urandom_range(lat_max, lat_min)),
                       stale: 1'b0});
      exp_fetch += 32'd4;
      ngnt++;
    end
    if (mem_rvalid) begin
      e = memq.pop_front();
      if (e.stale) ndrop++;
      else buffered++;
    end
    if (redir) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      buffered = 0;
      exp_pc = rpc & ~32'h3;
      exp_fetch = rpc & ~32'h3;
    end
    boot = 1'b0;
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, d0, dr0;
    bit found;
    bit rr;
    logic [31:0] tg;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, RPC,          1'b0, RPC};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00400000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00400004, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00400008, 1'b1, 32'h00400000};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040000C, 1'b1, 32'h00400004};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00400010, 1'b1, 32'h00400008};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00400014, 1'b1, 32'h0040000C};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00400018, 1'b1, 32'h00400010};

    // Streaming from reset, single-cycle grant and response.
    do_reset();
    lat_min = 1;
    lat_max = 1;
    rv_pct = 100;
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rdy, tbl[i].gnt, tbl[i].redir, tbl[i].rpc);
      chk("tbl_req", 32'(s_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk("tbl_addr", s_addr, tbl[i].e_addr);
      chk("tbl_valid", 32'(s_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid || i == 0) chk("tbl_pc", s_pc, tbl[i].e_pc);
      if (i == 0) chk("rst_instr", s_instr, NOP_INSTR);
    end

    // Stall: exactly DEPTH grants, then release and drain in order.
    do_reset();
    g0 = ngnt;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_grants", 32'(ngnt - g0), 32'(DEPTH));
    chk("stall_req", 32'(s_req), 32'd0);
    chk("stall_full", 32'(s_valid), 32'd1);
    d0 = ndeliv;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_four", 32'(ndeliv - d0), 32'd4);

    // Reset with a full queue.
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("full_before_rst", 32'(s_valid), 32'd1);
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_nop", s_instr, NOP_INSTR);
    chk("rst_req", 32'(s_req), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_addr", s_addr, RPC);
    chk("rst_req2", 32'(s_req), 32'd1);

    // Redirect with two responses outstanding.
    do_reset();
    lat_min = 4;
    lat_max = 4;
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    dr0 = ndrop;
    cyc(1'b1, 1'b0, 1'b1, 32'h00400040);
    chk("redir_noreq", 32'(s_req), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_req", 32'(s_req), 32'd1);
    chk("redir_addr", s_addr, 32'h00400040);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      if (!found && s_valid) begin
        found = 1'b1;
        chk("redir_first_pc", s_pc, 32'h00400040);
      end
    end
    chk("redir_seen", 32'(found), 32'd1);
    chk("redir_drops", 32'(ndrop - dr0), 32'd2);

    // Redirect while grant and response lines are both high.
    do_reset();
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h00400100);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_empty", 32'(s_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      if (!found && s_valid) begin
        found = 1'b1;
        chk("flush_first_pc", s_pc, 32'h00400100);
      end
    end
    chk("flush_seen", 32'(found), 32'd1);

    // Unaligned redirect target.
    cyc(1'b1, 1'b1, 1'b1, 32'h00400046);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("align_addr", s_addr, 32'h00400044);

    // Random traffic against the model.
    do_reset();
    lat_min = 1;
    lat_max = 3;
    rv_pct = 70;
    d0 = ndeliv;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        rr = ($urandom_range(99) < 4);
        if ($urandom_range(9) == 0) tg = 32'hFFFFFFF0 | ($urandom & 32'hF);
        else tg = RPC + ($urandom & 32'hFFFF);
        cyc($urandom_range(99) < 75, $urandom_range(99) < 70, rr, tg);
      end
    end
    chk("liveness", 32'(ndeliv - d0 > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
